// File: rtl/imem_loader.sv
// ============================================================================
// Module   : imem_loader
// Purpose  : Boot loader that streams a length-prefixed little-endian image
//            into instruction memory and holds the core in reset until done.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module imem_loader #(
   parameter int WORDS = 256,
   parameter int CNT_W = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_ready,
   output logic        imem_we,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic        core_reset,
   output logic        done,
   output logic        error
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LEN_LO = 3'd1,
      S_LEN_HI = 3'd2,
      S_DATA   = 3'd3,
      S_WRITE  = 3'd4,
      S_DONE   = 3'd5,
      S_ERR    = 3'd6
   } state_t;

   localparam logic [31:0]      c_words = 32'(WORDS);
   localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_len;
   logic [CNT_W-1:0] r_word_idx;
   logic [1:0]       r_byte_idx;
   logic [31:0]      r_wdata;

   logic             w_xfer;
   logic [CNT_W-1:0] w_len_new;
   logic             w_len_bad;
   logic             w_last_word;

   assign w_xfer      = rx_valid && rx_ready;
   // Length as it will stand once the high header byte is captured.
   assign w_len_new   = CNT_W'({rx_data, r_len[7:0]});
   assign w_len_bad   = (w_len_new == '0) ||
                        ({{(32-CNT_W){1'b0}}, w_len_new} > c_words);
   assign w_last_word = ((r_word_idx + c_one) == r_len);

   // Every output is a decode of the state register or a registered value.
   assign rx_ready   = (r_state == S_LEN_LO) || (r_state == S_LEN_HI) ||
                       (r_state == S_DATA);
   assign imem_we    = (r_state == S_WRITE);
   assign imem_addr  = 32'({r_word_idx, 2'b00});
   assign imem_wdata = r_wdata;
   assign core_reset = (r_state != S_DONE);
   assign done       = (r_state == S_DONE);
   assign error      = (r_state == S_ERR);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (start) w_next = S_LEN_LO;
         S_LEN_LO: if (w_xfer) w_next = S_LEN_HI;
         S_LEN_HI: if (w_xfer) w_next = w_len_bad ? S_ERR : S_DATA;
         S_DATA:   if (w_xfer && (r_byte_idx == 2'd3)) w_next = S_WRITE;
         S_WRITE:  w_next = w_last_word ? S_DONE : S_DATA;
         S_DONE:   if (start) w_next = S_LEN_LO;
         S_ERR:    if (start) w_next = S_LEN_LO;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_len      <= '0;
         r_word_idx <= '0;
         r_byte_idx <= '0;
         r_wdata    <= '0;
      end else begin
         case (r_state)
            S_LEN_LO: begin
               if (w_xfer) r_len[7:0] <= rx_data;
            end
            S_LEN_HI: begin
               if (w_xfer) begin
                  r_len[15:8] <= rx_data;
                  r_word_idx  <= '0;
                  r_byte_idx  <= '0;
               end
            end
            S_DATA: begin
               if (w_xfer) begin
                  r_wdata[8*r_byte_idx +: 8] <= rx_data;
                  r_byte_idx                 <= r_byte_idx + 2'd1;
               end
            end
            S_WRITE: begin
               r_word_idx <= r_word_idx + c_one;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

`default_nettype wire
